// File: rtl/cpu_control_if.sv
// Bus bundle between cpu_control and its environment.
//   Fetch side    : instr, instrValid (to CPU), instrReady, pc (from CPU)
//   Register file : dataA, dataB (to CPU), DataInRegg, Write,
//                   DAddress, AAddress, BAddress (from CPU)
// master = CPU side, slave = program memory / register file side.
interface cpu_control_if #(
    parameter int unsigned size = 8
);
    logic [size-1:0] instr;
    logic            instrValid;
    logic            instrReady;
    logic [size-1:0] pc;
    logic [size-1:0] dataA;
    logic [size-1:0] dataB;
    logic [size-1:0] DataInRegg;
    logic            Write;
    logic [1:0]      DAddress;
    logic [1:0]      AAddress;
    logic [1:0]      BAddress;

    modport master (
        input  instr, instrValid, dataA, dataB,
        output instrReady, pc, DataInRegg, Write, DAddress, AAddress, BAddress
    );

    modport slave (
        output instr, instrValid, dataA, dataB,
        input  instrReady, pc, DataInRegg, Write, DAddress, AAddress, BAddress
    );
endinterface

// File: rtl/cpu_control.sv
// Tiny byte-oriented CPU controller: fetches instruction/immediate bytes,
// executes one ALU op against an external 4-entry register file and writes
// the result back with a single-cycle Write pulse.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : cpu_control_if.master (fetch handshake + register file)
//   zeroFlag    : last flag-updating result was zero
//   carryFlag   : carry / borrow / shifted-out bit of last flag-updating op
//   halted      : HALT executed; only reset leaves this state
module cpu_control #(
    parameter int unsigned size = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_control_if.master bus,
    output logic          zeroFlag,
    output logic          carryFlag,
    output logic          halted
);

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_MOV  = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
    localparam logic [OP_W-1:0] OP_AND  = 4'h4;
    localparam logic [OP_W-1:0] OP_OR   = 4'h5;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h6;
    localparam logic [OP_W-1:0] OP_NOT  = 4'h7;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h8;
    localparam logic [OP_W-1:0] OP_SHL  = 4'h9;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_IMM,
        S_EXEC,
        S_WRITE,
        S_HALT
    } state_e;

    state_e          state_q,      state_d;
    logic [size-1:0] pc_q,         pc_d;
    logic [size-1:0] instr_q,      instr_d;
    logic [size-1:0] data_q,       data_d;
    logic            zero_q,       zero_d;
    logic            carry_q,      carry_d;
    logic            carry_pend_q, carry_pend_d;
    logic            halted_q,     halted_d;
    logic            ready_q,      ready_d;
    logic            write_q,      write_d;

    logic [OP_W-1:0] op;
    logic [size-1:0] alu_res;
    logic            alu_carry;
    logic [size:0]   sum_wide;
    logic            xfer;
    logic            op_writes;
    logic            op_flags;

    assign op   = instr_q[7:4];
    assign xfer = ready_q & bus.instrValid;

    // Opcode classes: which ops write back, which of those touch the flags
    always_comb begin
        op_writes = 1'b0;
        op_flags  = 1'b0;
        case (op)
            OP_MOV:                 op_writes = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_SHL: begin
                op_writes = 1'b1;
                op_flags  = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU on the combinational register-file read data
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        sum_wide  = {1'b0, bus.dataA} + {1'b0, bus.dataB};
        case (op)
            OP_MOV: alu_res = bus.dataB;
            OP_ADD: begin
                alu_res   = sum_wide[size-1:0];
                alu_carry = sum_wide[size];
            end
            OP_SUB: begin
                alu_res   = bus.dataA - bus.dataB;
                alu_carry = (bus.dataA < bus.dataB);
            end
            OP_AND: alu_res = bus.dataA & bus.dataB;
            OP_OR:  alu_res = bus.dataA | bus.dataB;
            OP_XOR: alu_res = bus.dataA ^ bus.dataB;
            OP_NOT: alu_res = ~bus.dataB;
            OP_SHL: begin
                alu_res   = {bus.dataB[size-2:0], 1'b0};
                alu_carry = bus.dataB[size-1];
            end
            default: ;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        data_d       = data_q;
        zero_d       = zero_q;
        carry_d      = carry_q;
        carry_pend_d = carry_pend_q;

        case (state_q)
            S_FETCH: begin
                if (xfer) begin
                    instr_d = bus.instr;
                    pc_d    = pc_q + size'(1);
                    state_d = (bus.instr[7:4] == OP_LDI) ? S_IMM : S_EXEC;
                end
            end
            S_IMM: begin
                if (xfer) begin
                    data_d  = bus.instr;
                    pc_d    = pc_q + size'(1);
                    state_d = S_WRITE;
                end
            end
            S_EXEC: begin
                data_d       = alu_res;
                carry_pend_d = alu_carry;
                if (op_writes) begin
                    state_d = S_WRITE;
                end else if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WRITE: begin
                // Flags commit together with the register-file write
                if (op_flags) begin
                    zero_d  = (data_q == '0);
                    carry_d = carry_pend_q;
                end
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Handshake/strobe outputs are registered, so derive them from the next state
        ready_d  = (state_d == S_FETCH) || (state_d == S_IMM);
        write_d  = (state_d == S_WRITE);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            instr_q      <= '0;
            data_q       <= '0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
            carry_pend_q <= 1'b0;
            halted_q     <= 1'b0;
            ready_q      <= 1'b0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            data_q       <= data_d;
            zero_q       <= zero_d;
            carry_q      <= carry_d;
            carry_pend_q <= carry_pend_d;
            halted_q     <= halted_d;
            ready_q      <= ready_d;
            write_q      <= write_d;
        end
    end

    // Reset asserted during WRITE must stop the register file from capturing
    // on the reset edge itself, so the strobe is qualified by rst_n.
    assign bus.Write      = write_q & rst_n;
    assign bus.instrReady = ready_q;
    assign bus.pc         = pc_q;
    assign bus.DataInRegg = data_q;
    assign bus.DAddress   = instr_q[3:2];
    assign bus.AAddress   = instr_q[3:2];
    assign bus.BAddress   = instr_q[1:0];
    assign zeroFlag       = zero_q;
    assign carryFlag      = carry_q;
    assign halted         = halted_q;

endmodule

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 Parameter: size, 8, datapath width of instruction bytes, register data and PC.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 instr  input  size  instruction or immediate byte from program memory.
REQ-005 instrValid  input  1  instr holds a valid byte.
REQ-006 instrReady  output  1  block accepts instr this cycle; byte transfers when instrValid and instrReady are both 1 at a rising edge.
REQ-007 pc  output  size  address of next byte to fetch.
REQ-008 dataA, dataB  input  size each  register-file read data for AAddress and BAddress (combinational read).
REQ-009 DataInRegg  output  size  write-back data to register file.
REQ-010 Write  output  1  register-file write enable.
REQ-011 DAddress, AAddress, BAddress  output  2 each  register-file write, read-A and read-B addresses.
REQ-012 zeroFlag, carryFlag  output  1 each  status flags.
REQ-013 halted  output  1  HALT executed.

Function
REQ-014 Instruction byte fields: op=[7:4], rd=[3:2], rb=[1:0]; DAddress=AAddress=rd, BAddress=rb while an instruction is held.
REQ-015 Opcodes: 0 NOP; 1 MOV rd<-B; 2 ADD rd<-A+B; 3 SUB rd<-A-B; 4 AND; 5 OR; 6 XOR; 7 NOT rd<-~B; 8 LDI rd<-next byte; 9 SHL rd<-B<<1; F HALT; A-E execute as NOP.
REQ-016 States: FETCH, IMM, EXEC, WRITE, HALT.
REQ-017 FETCH: instrReady=1; on transfer, latch instr, pc<=pc+1, go EXEC (LDI: go IMM); no transfer, stay.
REQ-018 IMM: instrReady=1; on transfer, latch byte into DataInRegg, pc<=pc+1, go WRITE; no transfer, stay.
REQ-019 EXEC: instrReady=0; register ALU result (from dataA/dataB) into DataInRegg; go WRITE for ops 1-7,9; go FETCH for NOP/undefined; go HALT for F.
REQ-020 WRITE: Write=1 for exactly this one cycle; register file captures DataInRegg at rd on the edge ending WRITE; update flags; go FETCH.
REQ-021 Write SHALL be 0 in every state other than WRITE.
REQ-022 Latency: ALU op accepted at edge t -> Write high during cycle t+2 -> instrReady high again cycle t+3; LDI adds one cycle plus any instrValid wait for immediate.
REQ-023 Arithmetic modulo 2^size; ADD carry=carry-out of bit size-1; SUB carry=borrow (1 when A<B unsigned); SHL carry=B[size-1]; AND/OR/XOR/NOT clear carry.
REQ-024 zeroFlag=1 when written result is 0, updated for ops 2-7,9 only; MOV, LDI, NOP leave both flags unchanged.
REQ-025 pc wraps 2^size-1 -> 0 with no other effect.
REQ-026 rd==rb legal: operands read before write (e.g. ADD R1,R1 doubles R1).
REQ-027 HALT: instrReady=0, Write=0, halted=1, pc frozen; left only by reset.
REQ-028 instr ignored whenever instrReady=0.

Reset
REQ-029 rst_n=0 at a rising edge: state<=FETCH, pc<=0, DataInRegg<=0, zeroFlag<=0, carryFlag<=0, halted<=0, latched instruction<=0 (address outputs 0).
REQ-030 Reset dominates all states including mid-EXEC/WRITE/IMM; Write=0 from the first cycle after the reset edge; no pending write completes.
REQ-031 During reset instrReady=0; instrReady=1 first cycle after rst_n returns high.

Verification
REQ-032 LDI R1 (0x84, 0x05) then LDI R2 (0x88, 0x03) -> Write pulses with DAddress=1/DataInRegg=0x05 then DAddress=2/0x03; pc=4.
REQ-033 R1=0x05,R2=0x03; SUB R1,R2 (0x36) -> Write with DataInRegg=0x02, carry=0, zero=0; then SUB R2,R1(new 0x02)... use R2=0x03,R1=0x05 SUB R2,R1 (0x39) -> 0xFE, carry=1.
REQ-034 R0=0xFF,R3=0x01; ADD R0,R3 (0x23) -> DataInRegg=0x00, zero=1, carry=1; following MOV leaves flags unchanged.
REQ-035 instrValid low 5 cycles in FETCH and in IMM -> instrReady stays 1, pc unchanged, no Write; resumes correctly when valid.
REQ-036 rst_n low during WRITE of ADD -> no write captured, all outputs at reset values next cycle; HALT (0xF0) then instrValid held high -> halted=1, instrReady=0, pc frozen until reset.
REQ-037 pc preloaded to 0xFF by 255 NOPs; one more fetch -> pc=0x00.
